// File: rtl/sr_pkg.sv
// Shared types and helpers for the storage-bank writer family (SR now, JK/T later).
// Holds the controller state encoding, the per-bit SR excitation rule and counter sizing.
package sr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    RESP
  } sr_state_e;

  // Per-bit excitation: returns {s, r}. Only one of them can be 1 for any input.
  function automatic logic [1:0] sr_excite(input logic target, input logic cur, input logic mask);
    return {mask & target & ~cur, mask & ~target & cur};
  endfunction

  // Bits needed to hold 0..max_value; never narrower than one bit.
  function automatic int unsigned count_w(input int unsigned max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/sr_excite_unit.sv
// Combinational excitation for a W-bit SR bank: set/reset pulses toward a target word
// plus the masked mismatch vector between current and target.
module sr_excite_unit
  import sr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] target,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] mask,
  output logic [W-1:0] s,
  output logic [W-1:0] r,
  output logic [W-1:0] mis
);

  // NOTE: defaults first so every path assigns s and r, which keeps this a pure mux with no latch.
  always_comb begin
    s = '0;
    r = '0;
    for (int i = 0; i < W; i++) begin
      {s[i], r[i]} = sr_excite(target[i], cur[i], mask[i]);
    end
  end

  // An X/Z bit in cur propagates here and is treated as a mismatch by the consumer.
  assign mis = (cur ^ target) & mask;

endmodule

// File: rtl/sr_bank_writer.sv
// Writes a masked target word into an SR flip-flop bank with pulse, settle and read-back,
// retrying mismatched bits a bounded number of times before reporting the result.
module sr_bank_writer
  import sr_pkg::*;
#(
  parameter int W          = 8,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [W-1:0]                        req_data,
  input  logic [W-1:0]                        req_mask,
  output logic [W-1:0]                        s_out,
  output logic [W-1:0]                        r_out,
  input  logic [W-1:0]                        q_in,
  output logic                                rsp_valid,
  output logic                                rsp_err,
  output logic [count_w(MAX_RETRY)-1:0]       rsp_retries
);

  localparam int RW  = count_w(MAX_RETRY);
  localparam int SCW = count_w(SETTLE_CYC - 1);

  sr_state_e      state_q;
  logic [W-1:0]   data_q;
  logic [W-1:0]   mask_q;
  logic [RW-1:0]  retry_q;
  logic [SCW-1:0] settle_cnt;

  logic [W-1:0]   ex_target;
  logic [W-1:0]   ex_mask;
  logic [W-1:0]   ex_s;
  logic [W-1:0]   ex_r;
  logic [W-1:0]   ex_mis;

  // First load uses the incoming request; retries reuse the latched word.
  assign ex_target = (state_q == IDLE) ? req_data : data_q;
  assign ex_mask   = (state_q == IDLE) ? req_mask : mask_q;

  sr_excite_unit #(.W(W)) u_excite (
    .target (ex_target),
    .cur    (q_in),
    .mask   (ex_mask),
    .s      (ex_s),
    .r      (ex_r),
    .mis    (ex_mis)
  );

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      req_ready   <= 1'b0;
      s_out       <= '0;
      r_out       <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_retries <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      retry_q     <= '0;
      settle_cnt  <= '0;
    end else begin
      // Pulses and the response strobe last exactly one cycle unless reloaded below.
      s_out     <= '0;
      r_out     <= '0;
      rsp_valid <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            data_q    <= req_data;
            mask_q    <= req_mask;
            s_out     <= ex_s;
            r_out     <= ex_r;
            retry_q   <= '0;
            req_ready <= 1'b0;
            state_q   <= DRIVE;
          end else begin
            req_ready <= 1'b1;
          end
        end

        DRIVE: begin
          settle_cnt <= SCW'(SETTLE_CYC - 1);
          state_q    <= SETTLE;
        end

        SETTLE: begin
          if (settle_cnt == '0) begin
            state_q <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        CHECK: begin
          // NOTE: test for the pass case so an unknown mismatch vector falls through to the failure paths.
          if (ex_mis == '0) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b0;
            rsp_retries <= retry_q;
            state_q     <= RESP;
          end else if (retry_q != RW'(MAX_RETRY)) begin
            retry_q <= retry_q + 1'b1;
            s_out   <= ex_s;
            r_out   <= ex_r;
            state_q <= DRIVE;
          end else begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_retries <= retry_q;
            state_q     <= RESP;
          end
        end

        RESP: begin
          req_ready <= 1'b1;
          state_q   <= IDLE;
        end

        default: begin
          req_ready <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_writer.sv
// Self-checking bench for sr_bank_writer: directed cases plus random traffic against
// a behavioural SR bank (with stuck, X and ignore-once faults) and an algorithmic model.
module tb_sr_bank_writer;

  localparam int W          = 8;
  localparam int SETTLE_CYC = 1;
  localparam int MAX_RETRY  = 2;
  localparam int RW         = 2;
  localparam int STEP       = 2 + SETTLE_CYC;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_data;
  logic [W-1:0]  req_mask;
  logic [W-1:0]  s_out;
  logic [W-1:0]  r_out;
  logic [W-1:0]  q_in;
  logic          rsp_valid;
  logic          rsp_err;
  logic [RW-1:0] rsp_retries;

  int n_checks = 0;
  int n_fail   = 0;

  sr_bank_writer #(.W(W), .SETTLE_CYC(SETTLE_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_mask    (req_mask),
    .s_out       (s_out),
    .r_out       (r_out),
    .q_in        (q_in),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_retries (rsp_retries)
  );

  always #5 CLK = ~CLK;

  // Behavioural SR bank: load port for presetting, stuck/X overrides and a one-shot ignore mask.
  logic [W-1:0] bank_q;
  logic [W-1:0] load_val, stuck0, stuck1, xmask, ign_mask;
  logic         load_en;
  int unsigned  pulse_cnt = 0;
  int unsigned  ign_at;

  always @(posedge CLK) begin
    logic [W-1:0] keep;
    keep = (pulse_cnt == ign_at) ? ~ign_mask : '1;
    if (load_en) begin
      bank_q <= load_val;
    end else if ((s_out | r_out) != '0) begin
      bank_q    <= (bank_q & ~(r_out & keep)) | (s_out & keep);
      pulse_cnt <= pulse_cnt + 1;
    end
  end

  function automatic logic [W-1:0] eff(input logic [W-1:0] b, input logic [W-1:0] st0,
                                       input logic [W-1:0] st1, input logic [W-1:0] xm);
    logic [W-1:0] e;
    for (int i = 0; i < W; i++)
      e[i] = xm[i] ? 1'bx : (st0[i] ? 1'b0 : (st1[i] ? 1'b1 : b[i]));
    return e;
  endfunction

  always_comb q_in = eff(bank_q, stuck0, stuck1, xmask);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the write algorithm should do against the bank described above.
  logic [W-1:0] exp_s[$];
  logic [W-1:0] exp_r[$];
  logic         exp_err;
  int           exp_ret;
  int           exp_lat;

  task automatic model(input logic [W-1:0] q0, input logic [W-1:0] data, input logic [W-1:0] mask,
                       input logic [W-1:0] st0, input logic [W-1:0] st1, input logic [W-1:0] xm,
                       input logic [W-1:0] ign);
    logic [W-1:0] b, e, s, r;
    exp_s.delete();
    exp_r.delete();
    b       = q0;
    exp_err = 1'b1;
    exp_ret = MAX_RETRY;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      e = eff(b, st0, st1, xm);
      s = mask & data & ~e;
      r = mask & ~data & e;
      exp_s.push_back(s);
      exp_r.push_back(r);
      if (a == 0) b = (b & ~(r & ~ign)) | (s & ~ign);
      else        b = (b & ~r) | s;
      if (((eff(b, st0, st1, xm) ^ data) & mask) === '0) begin
        exp_err = 1'b0;
        exp_ret = a;
        break;
      end
    end
    exp_lat = 3 + SETTLE_CYC + exp_ret * STEP;
  endtask

  // One full transaction; returns the first drive pulses and the observed response cycle.
  task automatic run_txn(input logic [W-1:0] q0, input logic [W-1:0] data, input logic [W-1:0] mask,
                         input logic [W-1:0] st0, input logic [W-1:0] st1, input logic [W-1:0] xm,
                         input logic [W-1:0] ign,
                         output logic [W-1:0] s1, output logic [W-1:0] r1, output int lat_obs);
    @(negedge CLK);
    load_en  = 1'b1;
    load_val = q0;
    stuck0   = st0;
    stuck1   = st1;
    xmask    = xm;
    ign_mask = ign;
    @(negedge CLK);
    load_en   = 1'b0;
    ign_at    = pulse_cnt;
    req_valid = 1'b1;
    req_data  = data;
    req_mask  = mask;
    check("ready_before_req", req_ready, 1);
    model(q0, data, mask, st0, st1, xm, ign);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    s1        = s_out;
    r1        = r_out;
    lat_obs   = 0;
    for (int cyc = 1; cyc <= exp_lat; cyc++) begin
      if (cyc > 1) begin
        @(posedge CLK);
        #1;
      end
      check("no_s_and_r", s_out & r_out, 0);
      if (((cyc - 1) % STEP == 0) && cyc < exp_lat) begin
        check("drive_s", s_out, exp_s[(cyc - 1) / STEP]);
        check("drive_r", r_out, exp_r[(cyc - 1) / STEP]);
      end else begin
        check("idle_s", s_out, 0);
        check("idle_r", r_out, 0);
      end
      check("busy_ready", req_ready, 0);
      check("rsp_valid_timing", rsp_valid, (cyc == exp_lat) ? 1 : 0);
      if (rsp_valid && lat_obs == 0) lat_obs = cyc;
    end
    check("rsp_err", rsp_err, exp_err);
    check("rsp_retries", rsp_retries, exp_ret);
    @(posedge CLK);
    #1;
    check("rsp_one_cycle", rsp_valid, 0);
    check("ready_after_rsp", req_ready, 1);
  endtask

  initial begin
    logic [W-1:0] s1, r1, d, m, q0, st0, st1, ig;
    int lat;

    RST       = 1'b1;
    req_valid = 1'b1;
    req_data  = 8'hA5;
    req_mask  = 8'hFF;
    load_en   = 1'b0;
    load_val  = '0;
    stuck0    = '0;
    stuck1    = '0;
    xmask     = '0;
    ign_mask  = '0;
    ign_at    = 0;

    // Reset holds everything low even with a request pending.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_s", s_out, 0);
      check("rst_r", r_out, 0);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_retries}, 0);
    end
    @(negedge CLK);
    RST       = 1'b0;
    req_valid = 1'b0;
    @(posedge CLK);
    #1;
    check("ready_after_rst", req_ready, 1);
    check("no_pulse_after_rst", s_out | r_out, 0);

    // Basic write.
    run_txn(8'h0F, 8'hF0, 8'hFF, '0, '0, '0, '0, s1, r1, lat);
    check("basic_s", s1, 8'hF0);
    check("basic_r", r1, 8'h0F);
    check("basic_lat", lat, 4);

    // Masked and already-equal bits.
    run_txn(8'hAA, 8'h55, 8'h0F, '0, '0, '0, '0, s1, r1, lat);
    check("masked_s", s1, 8'h05);
    check("masked_r", r1, 8'h0A);

    // Empty mask still walks the full sequence.
    run_txn(8'h3C, 8'hC3, 8'h00, '0, '0, '0, '0, s1, r1, lat);
    check("mask0_pulse", s1 | r1, 0);
    check("mask0_lat", lat, 4);
    check("mask0_err", rsp_err, 0);

    // Bit 3 ignores its first pulse: one retry driving only bit 3.
    run_txn(8'h00, 8'h3C, 8'hFF, '0, '0, '0, 8'h08, s1, r1, lat);
    check("retry_first_s", s1, 8'h3C);
    check("retry_second_s", exp_s[1], 8'h08);
    check("retry_lat", lat, 7);

    // Stuck-at-0 bit exhausts all retries.
    run_txn(8'h00, 8'h01, 8'hFF, 8'h01, '0, '0, '0, s1, r1, lat);
    check("stuck_s", s1, 8'h01);
    check("stuck_lat", lat, 10);
    check("stuck_err", rsp_err, 1);
    check("stuck_retries", rsp_retries, 2);

    // Unknown read-back on a masked bit is a mismatch.
    run_txn(8'h00, 8'h01, 8'h01, '0, '0, 8'h01, '0, s1, r1, lat);
    check("x_lat", lat, 10);
    check("x_err", rsp_err, 1);

    // Reset during DRIVE cuts the pulse and drops the request.
    @(negedge CLK);
    load_en  = 1'b1;
    load_val = 8'h0F;
    xmask    = '0;
    stuck0   = '0;
    ign_mask = '0;
    @(negedge CLK);
    load_en   = 1'b0;
    req_valid = 1'b1;
    req_data  = 8'hF0;
    req_mask  = 8'hFF;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    check("mid_drive_s", s_out, 8'hF0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_rst_s", s_out, 0);
    check("mid_rst_r", r_out, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_rsp", rsp_valid, 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1;
      check("mid_rst_no_rsp", rsp_valid, 0);
      check("mid_rst_no_pulse", s_out | r_out, 0);
    end
    check("mid_rst_ready_back", req_ready, 1);
    run_txn(8'h81, 8'h18, 8'hFF, '0, '0, '0, '0, s1, r1, lat);
    check("post_rst_lat", lat, 4);

    // Random traffic with occasional stuck bits and ignored first pulses.
    for (int t = 0; t < 24; t++) begin
      q0  = W'($urandom);
      d   = W'($urandom);
      m   = W'($urandom);
      st0 = ($urandom_range(3) == 0) ? W'(1 << $urandom_range(W - 1)) : '0;
      st1 = ($urandom_range(5) == 0) ? (W'($urandom) & ~st0 & m) : '0;
      ig  = ($urandom_range(2) == 0) ? W'($urandom) : '0;
      run_txn(q0, d, m, st0, st1, '0, ig, s1, r1, lat);
      check("rand_lat", lat, exp_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
